// File: rtl/unsigned_16by8_seq_div.sv
// -----------------------------------------------------------------------------
// unsigned_16by8_seq_div
//
// Sequential restoring divider: NW-bit unsigned dividend by DW-bit unsigned
// divisor, producing one quotient bit per clock. Used by the multiplier
// evaluation harness to recover operands from products. One division is in
// flight at a time; both sides use a valid/ready handshake.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     dividend/divisor presented
//   in_ready     block can accept an operation
//   dividend     NW-bit unsigned dividend
//   divisor      DW-bit unsigned divisor
//   out_valid    result available (held until out_ready)
//   out_ready    consumer accepts the result
//   quotient     NW-bit unsigned quotient ({NW{1'b1}} on divide-by-zero)
//   remainder    DW-bit unsigned remainder (dividend[DW-1:0] on divide-by-zero)
//   div_by_zero  result belongs to an operation whose divisor was 0
// -----------------------------------------------------------------------------
module unsigned_16by8_seq_div #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [NW-1:0] r_q;     // dividend shifts out of the top, quotient bits enter at the bottom
    logic [DW:0]   r_pr;    // partial remainder, one extra bit to hold 2*pr+1 before subtracting
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt;

    logic [DW:0]   w_pr_sh;
    logic          w_ge;
    logic [DW:0]   w_pr_nx;
    logic [NW-1:0] w_q_nx;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // pr < divisor holds before each step, so the shifted value fits in DW+1 bits.
    assign w_pr_sh = {r_pr[DW-1:0], r_q[NW-1]};
    assign w_ge    = (w_pr_sh >= {1'b0, r_div});
    assign w_pr_nx = w_ge ? (w_pr_sh - {1'b0, r_div}) : w_pr_sh;
    assign w_q_nx  = {r_q[NW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_pr        <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            // No iterations needed: the result is defined directly.
                            r_state     <= S_DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[DW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= S_BUSY;
                            r_div   <= divisor;
                            r_q     <= dividend;
                            r_pr    <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    r_q   <= w_q_nx;
                    r_pr  <= w_pr_nx;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(NW - 1)) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        quotient  <= w_q_nx;
                        remainder <= w_pr_nx[DW-1:0];
                    end
                end
                S_DONE: begin
                    // The output handshake never overlaps an input accept:
                    // in_ready only rises on the edge that leaves DONE.
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        out_valid   <= 1'b0;
                        div_by_zero <= 1'b0;
                        in_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_16by8_seq_div.sv
module tb_unsigned_16by8_seq_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    unsigned_16by8_seq_div #(.NW(16), .DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and collect the result. lat counts rising edges
    // after the accept edge until out_valid is seen (a zero divisor completes
    // on the accept edge, so its result is up in the cycle right after accept).
    // If rdy is set, out_ready is high and the handshake edge is also taken;
    // rdy_after reports in_ready just after that edge.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] ds, input bit rdy,
                          output int lat, output logic [15:0] q, output logic [7:0] r,
                          output logic z, output bit busy_rdy, output logic rdy_after,
                          output logic ov_after);
        int w;
        w = 0;
        out_ready = rdy;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        in_valid = 1'b1;
        dividend = dd;
        divisor  = ds;
        tick();
        in_valid = 1'b0;
        dividend = 16'hA5A5;
        divisor  = 8'h3C;
        busy_rdy = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_rdy = 1'b1;
            tick();
            lat++;
        end
        if (in_ready) busy_rdy = 1'b1;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        rdy_after = 1'bx;
        ov_after  = 1'bx;
        if (rdy) begin
            tick();
            rdy_after = in_ready;
            ov_after  = out_valid;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0})
            $display("FAIL reset: in_ready=%b out_valid=%b q=%0d r=%0d dbz=%b, expected 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        else n_pass++;
    endtask

    task automatic test_basic();
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        run_op(16'd1000, 8'd7, 1'b1, lat, q, r, z, br, ra, oa);
        n_checks++;
        if (lat !== 16) $display("FAIL basic_latency: got %0d expected 16", lat);
        else n_pass++;
        n_checks++;
        if ({q, r, z} !== {16'd142, 8'd6, 1'b0})
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected q=142 r=6 dbz=0", q, r, z);
        else n_pass++;
        n_checks++;
        if (br !== 1'b0) $display("FAIL basic_in_ready_busy: got in_ready high while busy, expected low");
        else n_pass++;
        n_checks++;
        if ({ra, oa} !== 2'b10)
            $display("FAIL basic_handshake: got in_ready=%b out_valid=%b expected 1 0", ra, oa);
        else n_pass++;
    endtask

    task automatic test_extremes();
        logic [15:0] dd [3] = '{16'd65535, 16'd65025, 16'd5};
        logic [7:0]  ds [3] = '{8'd1, 8'd255, 8'd200};
        logic [15:0] eq [3] = '{16'd65535, 16'd255, 16'd0};
        logic [7:0]  er [3] = '{8'd0, 8'd0, 8'd5};
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        for (int i = 0; i < 3; i++) begin
            run_op(dd[i], ds[i], 1'b1, lat, q, r, z, br, ra, oa);
            n_checks++;
            if ({q, r, z} !== {eq[i], er[i], 1'b0} || lat !== 16)
                $display("FAIL extreme_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d expected q=%0d r=%0d dbz=0 lat=16",
                         i, dd[i], ds[i], q, r, z, lat, eq[i], er[i]);
            else n_pass++;
        end
    endtask

    task automatic test_div_by_zero();
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        run_op(16'h04D2, 8'd0, 1'b1, lat, q, r, z, br, ra, oa);
        n_checks++;
        if (lat !== 0) $display("FAIL dbz_latency: got %0d edges after accept, expected 0 (valid in next cycle)", lat);
        else n_pass++;
        n_checks++;
        if ({q, r, z} !== {16'hFFFF, 8'hD2, 1'b1})
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b expected q=ffff r=d2 dbz=1", q, r, z);
        else n_pass++;
        n_checks++;
        if ({ra, oa} !== 2'b10)
            $display("FAIL dbz_handshake: got in_ready=%b out_valid=%b expected 1 0", ra, oa);
        else n_pass++;
        run_op(16'd100, 8'd10, 1'b1, lat, q, r, z, br, ra, oa);
        n_checks++;
        if ({q, r, z} !== {16'd10, 8'd0, 1'b0} || lat !== 16)
            $display("FAIL dbz_followup: got q=%0d r=%0d dbz=%b lat=%0d expected q=10 r=0 dbz=0 lat=16", q, r, z, lat);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        bit stable;
        run_op(16'd1000, 8'd7, 1'b0, lat, q, r, z, br, ra, oa);
        n_checks++;
        if ({q, r, z} !== {16'd142, 8'd6, 1'b0} || lat !== 16)
            $display("FAIL bp_result: got q=%0d r=%0d dbz=%b lat=%0d expected q=142 r=6 dbz=0 lat=16", q, r, z, lat);
        else n_pass++;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            dividend = 16'd1234;
            divisor  = 8'd5;
            tick();
            if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd142, 8'd6, 1'b0})
                stable = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (stable !== 1'b1)
            $display("FAIL bp_hold: got ov=%b in_ready=%b q=%0d r=%0d expected held 1 0 142 6",
                     out_valid, in_ready, quotient, remainder);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL bp_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        bit saw_valid;
        out_ready = 1'b1;
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd3;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0})
            $display("FAIL midreset_state: got in_ready=%b ov=%b q=%0d r=%0d dbz=%b expected 1 0 0 0 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        else n_pass++;
        saw_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) $display("FAIL midreset_no_result: got out_valid=1 expected 0");
        else n_pass++;
        run_op(16'd40000, 8'd3, 1'b1, lat, q, r, z, br, ra, oa);
        n_checks++;
        if ({q, r, z} !== {16'd13333, 8'd1, 1'b0} || lat !== 16)
            $display("FAIL midreset_rerun: got q=%0d r=%0d dbz=%b lat=%0d expected q=13333 r=1 dbz=0 lat=16", q, r, z, lat);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic [15:0] q; logic [7:0] r; logic z; bit br; logic ra, oa;
        logic [15:0] dd; logic [7:0] ds;
        logic [31:0] recon;
        int gap;
        for (int n = 0; n < 300; n++) begin
            dd = 16'($urandom);
            ds = (n % 25 == 0) ? 8'd0 : 8'($urandom);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            run_op(dd, ds, 1'b0, lat, q, r, z, br, ra, oa);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_checks++;
            if (ds == 8'd0) begin
                if ({q, r, z} !== {16'hFFFF, dd[7:0], 1'b1} || lat !== 0)
                    $display("FAIL random_dbz_%0d: %0d/0 got q=%h r=%h dbz=%b lat=%0d expected ffff %h 1 lat=0",
                             n, dd, q, r, z, lat, dd[7:0]);
                else n_pass++;
            end else begin
                recon = 32'(q) * 32'(ds) + 32'(r);
                if (recon !== 32'(dd) || r >= ds || z !== 1'b0 || lat !== 16 || q !== dd / 16'(ds))
                    $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d dbz=%b lat=%0d expected q=%0d r=%0d dbz=0 lat=16",
                             n, dd, ds, q, r, z, lat, dd / 16'(ds), dd % 16'(ds));
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
